// File: rtl/ped_crossing_scheduler_if.sv
// rtl/ped_crossing_scheduler_if.sv - signal bundle between the crossing scheduler and the controller side
interface ped_crossing_scheduler_if;
    logic       enable_i;
    logic [1:0] req_i;
    logic [2:0] phase_i;
    logic       tick_o;
    logic [1:0] walk_o;
    logic [1:0] pend_o;
    logic [3:0] cnt_o;

    modport master (
        output enable_i, req_i, phase_i,
        input  tick_o, walk_o, pend_o, cnt_o
    );

    modport slave (
        input  enable_i, req_i, phase_i,
        output tick_o, walk_o, pend_o, cnt_o
    );
endinterface

// File: rtl/ped_crossing_scheduler.sv
// rtl/ped_crossing_scheduler.sv - tick prescaler, button debounce and walk scheduling around all-red phases
// Optional: PED_REQ_LATCH_EN keeps presses from the granted direction made during WALK/CLEAR.
module ped_crossing_scheduler #(
    parameter int CLK_DIV   = 100000000,
    parameter int DB_CYCLES = 65535,
    parameter int WALK_LEN  = 5,
    parameter int CLR_LEN   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ped_crossing_scheduler_if.slave  ped
);
    localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES);

    typedef enum logic [1:0] {IDLE, WALK, CLEAR} state_t;

    state_t         state_q;
    logic [PW-1:0]  pre_q;
    logic           tick_q;
    logic [1:0]     sync1_q, sync2_q, stable_q;
    logic [DBW-1:0] db_cnt_q [2];
    logic [2:0]     phase_q;
    logic [1:0]     pend_q, walk_q;
    logic [3:0]     cnt_q;
    logic           rr_q, g_q;
    logic [1:0]     press, pend_set, pend_d;
    logic           entry, grant, walk_end;
`ifdef PED_REQ_LATCH_EN
    logic           lat_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            phase_q <= '0;
        end else begin
            pre_q   <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            tick_q  <= (pre_q == PRE_LAST);
            phase_q <= ped.phase_i;
        end
    end

    // Stable level only follows the synced level after DB_CYCLES unbroken mismatching cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q <= ped.req_i;
            sync2_q <= sync1_q;
            for (int k = 0; k < 2; k++) begin
                if (sync2_q[k] == stable_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    stable_q[k] <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DBW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            press[k] = sync2_q[k] & ~stable_q[k] & (db_cnt_q[k] == DB_LAST);
        end
        entry    = (ped.phase_i != phase_q) && (ped.phase_i == 3'd2 || ped.phase_i == 3'd5);
        grant    = (pend_q == 2'b11) ? rr_q : pend_q[1];
        walk_end = (state_q == WALK) && tick_q && (cnt_q == 4'd1);
        pend_set = press;
`ifdef PED_REQ_LATCH_EN
        if (state_q == WALK) pend_set[g_q] = 1'b0;
`else
        if (state_q != IDLE) pend_set[g_q] = 1'b0;
`endif
        pend_d = pend_q | pend_set;
`ifdef PED_REQ_LATCH_EN
        if (walk_end) pend_d[g_q] = lat_q | press[g_q];
`else
        if (walk_end) pend_d[g_q] = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            walk_q  <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            g_q     <= 1'b0;
`ifdef PED_REQ_LATCH_EN
            lat_q   <= 1'b0;
`endif
        end else if (!ped.enable_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            walk_q  <= '0;
            cnt_q   <= '0;
`ifdef PED_REQ_LATCH_EN
            lat_q   <= 1'b0;
`endif
        end else begin
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (entry && pend_q != 2'b00) begin
                        state_q <= WALK;
                        cnt_q   <= 4'(WALK_LEN);
                        g_q     <= grant;
                        walk_q  <= grant ? 2'b10 : 2'b01;
                    end
                end
                WALK: begin
`ifdef PED_REQ_LATCH_EN
                    if (press[g_q] && !walk_end) lat_q <= 1'b1;
                    if (walk_end) lat_q <= 1'b0;
`endif
                    if (walk_end) begin
                        rr_q   <= ~g_q;
                        walk_q <= '0;
                        if (CLR_LEN == 0) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= CLEAR;
                            cnt_q   <= 4'(CLR_LEN);
                        end
                    end else if (tick_q) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CLEAR: begin
                    if (tick_q) begin
                        if (cnt_q == 4'd1) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ped.tick_o = tick_q & (state_q == IDLE);
    assign ped.walk_o = walk_q;
    assign ped.pend_o = pend_q;
    assign ped.cnt_o  = cnt_q;
endmodule
